// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the LEGv8 fetch stage: fetch FSM states, SignExtender
// control codes and the opcode patterns that select them.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_t;

   typedef enum logic [2:0] {
      SEXT_I  = 3'd0,
      SEXT_D  = 3'd1,
      SEXT_B  = 3'd2,
      SEXT_CB = 3'd3,
      SEXT_IM = 3'd4
   } sext_ctrl_t;

   // Opcode prefixes, left-aligned to Instruction[31]
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [6:0]  OP_CB   = 7'b1011010;
   localparam logic [8:0]  OP_MOVZ = 9'b110100101;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;

   localparam logic [63:0] PC_STEP = 64'd4;

   // Sequential successor; wraps modulo 2^64 by construction
   function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch stage's instruction-memory port and its downstream
// pipeline/decode handshake.
interface instruction_fetch_unit_if;

   // Memory: IMemReq is held with IMemAddr stable until a cycle with IMemReady,
   // which completes the request. Downstream: a word is consumed in any cycle
   // with Valid && !Stall; Redirect discards the current or in-flight word.
   logic        IMemReq;
   logic [63:0] IMemAddr;
   logic        IMemReady;
   logic [31:0] IMemData;
   logic        Stall;
   logic        Redirect;
   logic [63:0] RedirectPC;
   logic        Valid;
   logic [31:0] Instruction;
   logic [63:0] CurrentPC;
   logic [25:0] SignImmInput;
   logic [2:0]  SignExtCtrl;

   modport master (
      output IMemReq, IMemAddr, Valid, Instruction, CurrentPC, SignImmInput, SignExtCtrl,
      input  IMemReady, IMemData, Stall, Redirect, RedirectPC
   );

   modport slave (
      input  IMemReq, IMemAddr, Valid, Instruction, CurrentPC, SignImmInput, SignExtCtrl,
      output IMemReady, IMemData, Stall, Redirect, RedirectPC
   );

endinterface

// File: rtl/instruction_fetch_unit_imm_ctrl_decode.sv
// Combinational immediate-type decode feeding SignExtender.Ctrl from the top
// eleven instruction bits; first matching pattern wins.
module instruction_fetch_unit_imm_ctrl_decode
   import instruction_fetch_unit_pkg::*;
(
   input  logic [10:0] i_opcode,
   output sext_ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = SEXT_I;
      if (i_opcode[10:5] == OP_B) begin
         o_ctrl = SEXT_B;
      end else if (i_opcode[10:4] == OP_CB) begin
         o_ctrl = SEXT_CB;
      end else if (i_opcode[10:2] == OP_MOVZ) begin
         o_ctrl = SEXT_IM;
      end else if ((i_opcode == OP_LDUR) || (i_opcode == OP_STUR)) begin
         o_ctrl = SEXT_D;
      end else if ((i_opcode[10:1] == OP_ADDI) || (i_opcode[10:1] == OP_SUBI)) begin
         o_ctrl = SEXT_I;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, issues one outstanding instruction-memory
// request at a time and holds each fetched word until downstream consumes it.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)(
   input  logic                     CLK,
   input  logic                     Reset,
   instruction_fetch_unit_if.master bus,
   output fetch_state_t             o_dbg_state
);

   fetch_state_t r_state;
   logic [63:0]  r_pc;
   logic [63:0]  r_target;
   logic [31:0]  r_instr;
   logic [63:0]  r_cur_pc;

   fetch_state_t w_state_next;
   logic [63:0]  w_pc_next;
   logic [63:0]  w_target_next;
   logic [31:0]  w_instr_next;
   logic [63:0]  w_cur_pc_next;
   logic         w_req;
   logic         w_valid;
   sext_ctrl_t   w_sext_ctrl;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state  <= ST_IDLE;
         r_pc     <= RESET_PC;
         r_target <= RESET_PC;
         r_instr  <= 32'h0;
         r_cur_pc <= RESET_PC;
      end else begin
         r_state  <= w_state_next;
         r_pc     <= w_pc_next;
         r_target <= w_target_next;
         r_instr  <= w_instr_next;
         r_cur_pc <= w_cur_pc_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_target_next = r_target;
      w_instr_next  = r_instr;
      w_cur_pc_next = r_cur_pc;
      w_req         = 1'b0;
      w_valid       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_FETCH;
            if (bus.Redirect) begin
               w_pc_next = bus.RedirectPC;
            end
         end
         ST_FETCH: begin
            w_req = 1'b1;
            if (bus.IMemReady) begin
               if (bus.Redirect) begin
                  w_pc_next = bus.RedirectPC;
               end else begin
                  w_instr_next  = bus.IMemData;
                  w_cur_pc_next = r_pc;
                  w_state_next  = ST_HOLD;
               end
            end else if (bus.Redirect) begin
               // Request must complete at its original address; remember where to go after
               w_target_next = bus.RedirectPC;
               w_state_next  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_req = 1'b1;
            if (bus.Redirect) begin
               w_target_next = bus.RedirectPC;
            end
            if (bus.IMemReady) begin
               w_pc_next    = bus.Redirect ? bus.RedirectPC : r_target;
               w_state_next = ST_FETCH;
            end
         end
         ST_HOLD: begin
            w_valid = 1'b1;
            if (bus.Redirect) begin
               w_pc_next    = bus.RedirectPC;
               w_state_next = ST_FETCH;
            end else if (!bus.Stall) begin
               w_pc_next    = next_seq_pc(r_cur_pc);
               w_state_next = ST_FETCH;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   instruction_fetch_unit_imm_ctrl_decode u_imm_ctrl_decode (
      .i_opcode (r_instr[31:21]),
      .o_ctrl   (w_sext_ctrl)
   );

   assign bus.IMemReq      = w_req;
   assign bus.IMemAddr     = r_pc;
   assign bus.Valid        = w_valid;
   assign bus.Instruction  = r_instr;
   assign bus.CurrentPC    = r_cur_pc;
   assign bus.SignImmInput = r_instr[25:0];
   assign bus.SignExtCtrl  = w_sext_ctrl;
   assign o_dbg_state      = r_state;

endmodule
